// File: rtl/fft_result_streamer.sv
// fft_result_streamer: after the FFT core signals done, reads every result word
// from the result RAM and presents it as a valid/ready stream with index and last flag.
module fft_result_streamer #(
  parameter int unsigned N       = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BIT_REV = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic [ADDR_W-1:0] out_cnt_q;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic              frame_done_q;
  logic              overrun_q;

  logic              beat;
  logic              fifo_empty;
  logic              fifo_push, fifo_pop, bypass_pop;
  logic [1:0]        occ_after_pop;
  logic              credit_ok;
  logic              rd_en;
  logic              start;
  logic              last_beat;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      r[i] = v[ADDR_W-1-i];
    end
    return r;
  endfunction

  assign fifo_empty = (count_q == 2'd0);
  assign beat       = m_valid && m_ready;

  // A word whose RAM read is in flight is already visible on m_data when the
  // FIFO is empty; accepting it there means it never enters the FIFO.
  assign bypass_pop = beat && fifo_empty;
  assign fifo_pop   = beat && !fifo_empty;
  assign fifo_push  = inflight_q && !bypass_pop;

  // Credit counts stored words plus the in-flight read, less this cycle's beat.
  assign occ_after_pop = count_q + {1'b0, inflight_q} - {1'b0, beat};
  assign credit_ok     = (occ_after_pop < 2'd2);

  assign start     = (state_q == IDLE) && fft_done;
  assign last_beat = beat && (out_cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fft_done) state_d = STREAM;
      end
      STREAM: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (rd_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;

      if (start) begin
        rd_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (rd_en && (rd_cnt_q != LAST_IDX)) rd_cnt_q <= rd_cnt_q + 1'b1;
        if (beat) out_cnt_q <= out_cnt_q + 1'b1;
      end

      if (fifo_push) begin
        fifo_mem[wr_ptr_q] <= ram_rd_data;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      if (fifo_push && !fifo_pop) begin
        count_q <= count_q + 2'd1;
      end else if (!fifo_push && fifo_pop) begin
        count_q <= count_q - 2'd1;
      end

      frame_done_q <= (state_q == DRAIN) && last_beat;
      if (fft_done && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

  assign ram_rd_en   = rd_en;
  assign ram_rd_addr = (BIT_REV != 0) ? bitrev(rd_cnt_q) : rd_cnt_q;
  assign m_valid     = !fifo_empty || inflight_q;
  assign m_data      = !fifo_empty ? fifo_mem[rd_ptr_q] :
                       (inflight_q ? ram_rd_data : '0);
  assign m_index     = out_cnt_q;
  assign m_last      = m_valid && (out_cnt_q == LAST_IDX);
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: RAM models, expected-word queues filled at fft_done,
// and negedge monitors that pop and compare every output word.
module tb_fft_result_streamer;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        fft_done = 1'b0;
  logic        ram_rd_en;
  logic [9:0]  ram_rd_addr;
  logic [31:0] ram_rd_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [9:0]  m_index;
  logic        m_last;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  logic        fft_done_b = 1'b0;
  logic        ram_rd_en_b;
  logic [9:0]  ram_rd_addr_b;
  logic [31:0] ram_rd_data_b = '0;
  logic        m_valid_b;
  logic        m_ready_b = 1'b1;
  logic [31:0] m_data_b;
  logic [9:0]  m_index_b;
  logic        m_last_b;
  logic        busy_b;
  logic        frame_done_b;
  logic        overrun_b;

  logic [31:0] ram0 [N];
  logic [31:0] ram1 [N];

  logic [42:0] q0[$];
  logic [42:0] q1[$];
  logic [42:0] e0, e1;
  logic        beat0, beat1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int occ0 = 0;
  int rd_issued0 = 0, rd_issued1 = 0;
  int beats0 = 0, beats1 = 0;
  int fd0 = 0, fd1 = 0;
  int first_cyc0 = 0, last_cyc0 = 0, fd_cyc0 = 0, start_cyc0 = 0;

  fft_result_streamer #(.N(1024), .ADDR_W(10), .DATA_W(32), .BIT_REV(0)) u0 (
    .clk(clk), .rst(rst), .fft_done(fft_done),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  fft_result_streamer #(.N(1024), .ADDR_W(10), .DATA_W(32), .BIT_REV(1)) u1 (
    .clk(clk), .rst(rst), .fft_done(fft_done_b),
    .ram_rd_en(ram_rd_en_b), .ram_rd_addr(ram_rd_addr_b), .ram_rd_data(ram_rd_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_index(m_index_b),
    .m_last(m_last_b), .busy(busy_b), .frame_done(frame_done_b), .overrun(overrun_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_rd_en)   ram_rd_data   <= ram0[ram_rd_addr];
    if (ram_rd_en_b) ram_rd_data_b <= ram1[ram_rd_addr_b];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] rev10(input int v);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r = {r[8:0], v[i]};
    return r;
  endfunction

  // Monitor for the natural-order instance.
  always @(negedge clk) begin
    if (!rst) begin
      beat0 = m_valid && m_ready;
      check("m_valid", m_valid, occ0 != 0);
      if (m_valid) begin
        if (q0.size() == 0) begin
          check("extra_word", 1'b1, 1'b0);
        end else begin
          e0 = q0[0];
          check("m_data", m_data, e0[31:0]);
          check("m_index", m_index, e0[41:32]);
          check("m_last", m_last, e0[42]);
          if (beat0) begin
            void'(q0.pop_front());
            beats0++;
            if (beats0 == 1) first_cyc0 = cyc;
            last_cyc0 = cyc;
          end
        end
      end else begin
        check("m_last_idle", m_last, 1'b0);
      end
      if (ram_rd_en) begin
        check("credit", (occ0 - int'(beat0)) < 2, 1'b1);
        check("rd_addr", ram_rd_addr, rd_issued0[9:0]);
        rd_issued0++;
      end
      occ0 = occ0 + int'(ram_rd_en) - int'(beat0);
      if (frame_done) begin
        fd0++;
        fd_cyc0 = cyc;
      end
    end
  end

  // Monitor for the bit-reversed instance.
  always @(negedge clk) begin
    if (!rst) begin
      beat1 = m_valid_b && m_ready_b;
      if (beat1) begin
        if (q1.size() == 0) begin
          check("b_extra_word", 1'b1, 1'b0);
        end else begin
          e1 = q1.pop_front();
          check("b_m_data", m_data_b, e1[31:0]);
          check("b_m_index", m_index_b, e1[41:32]);
          check("b_m_last", m_last_b, e1[42]);
          beats1++;
        end
      end
      if (ram_rd_en_b) begin
        check("b_rd_addr", ram_rd_addr_b, rev10(rd_issued1));
        rd_issued1++;
      end
      if (frame_done_b) fd1++;
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    occ0 = 0;
    rd_issued0 = 0;
    rd_issued1 = 0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_frame0();
    for (int k = 0; k < N; k++) q0.push_back({(k == N - 1), 10'(k), ram0[k]});
    rd_issued0 = 0;
    beats0 = 0;
    start_cyc0 = cyc;
    fft_done = 1'b1;
    @(posedge clk);
    #1 fft_done = 1'b0;
  endtask

  task automatic start_frame1();
    for (int k = 0; k < N; k++) q1.push_back({(k == N - 1), 10'(k), ram1[rev10(k)]});
    rd_issued1 = 0;
    beats1 = 0;
    fft_done_b = 1'b1;
    @(posedge clk);
    #1 fft_done_b = 1'b0;
  endtask

  task automatic wait_beats0(input int target, input int limit);
    int n = 0;
    while (beats0 < target && n < limit) begin
      @(posedge clk);
      #1 n++;
    end
    check("beats_reached", beats0 >= target, 1'b1);
  endtask

  task automatic wait_frame0(input int limit);
    int n = 0;
    int f = fd0;
    while (fd0 == f && n < limit) begin
      @(posedge clk);
      #1 n++;
    end
    check("frame_done_seen", fd0 != f, 1'b1);
  endtask

  initial begin
    int f;
    int n;
    for (int i = 0; i < N; i++) begin
      ram0[i] = i;
      ram1[i] = i;
    end

    // 1: reset, then reset again with a word held in the FIFO
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outs", {ram_rd_en, ram_rd_addr, m_valid, m_data, m_index, m_last,
                         busy, frame_done, overrun}, 64'h0);
    m_ready = 1'b0;
    start_frame0();
    repeat (2) @(posedge clk);
    #1;
    check("stalled_valid", m_valid, 1'b1);
    do_reset(1);
    check("midreset_outs", {ram_rd_en, ram_rd_addr, m_valid, m_data, m_index, m_last,
                            busy, frame_done, overrun}, 64'h0);

    // 2: full frame at full throughput
    m_ready = 1'b1;
    start_frame0();
    wait_frame0(N + 20);
    check("beats", beats0, N);
    check("first_beat_lat", first_cyc0 - start_cyc0, 2);
    check("last_beat_lat", last_cyc0 - start_cyc0, N + 1);
    check("frame_done_lat", fd_cyc0 - start_cyc0, N + 2);
    check("no_bubbles", last_cyc0 - first_cyc0 + 1, N);
    check("q_empty", q0.size(), 0);

    // 6: fft_done together with frame_done, then abort by reset
    start_frame0();
    wait_beats0(N, N + 20);
    start_frame0();
    check("fd_coincide", fd_cyc0, start_cyc0);
    check("restart_busy", busy, 1'b1);
    wait_beats0(300, 400);
    check("no_overrun", overrun, 1'b0);
    do_reset(1);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", m_valid, 1'b0);
    check("abort_fd", frame_done, 1'b0);
    f = fd0;
    repeat (30) @(posedge clk);
    #1 check("abort_no_fd", fd0, f);

    // 3: random backpressure
    for (int i = 0; i < N; i++) ram0[i] = {i[15:0], ~i[15:0]};
    void'($urandom(32'h5eed1234));
    start_frame0();
    n = 0;
    while (beats0 < N && n < 8 * N) begin
      m_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      #1 n++;
    end
    m_ready = 1'b1;
    wait_frame0(20);
    check("bp_beats", beats0, N);
    check("bp_q_empty", q0.size(), 0);

    // 4: bit-reversed read order
    start_frame1();
    n = 0;
    while (fd1 == 0 && n < N + 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("b_frame_done", fd1, 1);
    check("b_beats", beats1, N);

    // 5: extra fft_done mid-frame
    start_frame0();
    repeat (500) @(posedge clk);
    #1 fft_done = 1'b1;
    @(posedge clk);
    #1 fft_done = 1'b0;
    check("overrun_set", overrun, 1'b1);
    wait_frame0(N + 20);
    check("ovr_beats", beats0, N);
    repeat (20) @(posedge clk);
    #1;
    check("ovr_no_restart", busy, 1'b0);
    check("ovr_beats_after", beats0, N);
    check("overrun_sticky", overrun, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
